// File: rtl/reg_file_8x16.sv
// 8x16 register file: two combinational read ports, one write port, R7 is the auto-incrementing PC.
// Pending-write scoreboard (busy) for RAW stalls; REGFILE_BYPASS_EN adds write-through forwarding.
module reg_file_8x16 #(
    parameter int                DATA_W   = 16,
    parameter int                NREG     = 8,
    parameter int                ADDR_W   = 3,
    parameter logic [DATA_W-1:0] PC_RESET = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic              ra_busy,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_busy,
    input  logic              wr_n,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_n,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] pc_out,
    output logic [NREG-1:0]   busy
);

    localparam int PC_IDX = NREG - 1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic              wr_en;
    logic              rsv_en;

    assign wr_en  = ~wr_n;
    assign rsv_en = ~rsv_n;

    // Ordering gives the priorities: a write overrides pc_inc on R7, a reserve overrides the write's busy clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (pc_inc) begin
            regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_W'(1);
        end
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == PC_IDX) ? PC_RESET : '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign pc_out = regs_q[PC_IDX];
    assign busy   = busy_q;

`ifdef REGFILE_BYPASS_EN
    logic byp_a;
    logic byp_b;
    logic byp_busy;

    // A forwarded operand is no longer pending unless it is being re-reserved this same cycle.
    assign byp_a    = wr_en && (ra_addr == wr_addr);
    assign byp_b    = wr_en && (rb_addr == wr_addr);
    assign byp_busy = rsv_en && (rsv_addr == wr_addr);

    assign ra_data = byp_a ? wr_data  : regs_q[ra_addr];
    assign rb_data = byp_b ? wr_data  : regs_q[rb_addr];
    assign ra_busy = byp_a ? byp_busy : busy_q[ra_addr];
    assign rb_busy = byp_b ? byp_busy : busy_q[rb_addr];
`else
    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];
    assign ra_busy = busy_q[ra_addr];
    assign rb_busy = busy_q[rb_addr];
`endif

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed bench for reg_file_8x16; stimulus queues expectations, a negedge monitor checks them.
module tb_reg_file_8x16;

    localparam logic [15:0] PC_RST = 16'h0000;

    localparam int S_RA_DATA = 0;
    localparam int S_RB_DATA = 1;
    localparam int S_RA_BUSY = 2;
    localparam int S_RB_BUSY = 3;
    localparam int S_PC      = 4;
    localparam int S_BUSY    = 5;

    logic        clk;
    logic        reset;
    logic [2:0]  ra_addr;
    logic [15:0] ra_data;
    logic        ra_busy;
    logic [2:0]  rb_addr;
    logic [15:0] rb_data;
    logic        rb_busy;
    logic        wr_n;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_n;
    logic [2:0]  rsv_addr;
    logic        pc_inc;
    logic [15:0] pc_out;
    logic [7:0]  busy;

    reg_file_8x16 #(.PC_RESET(PC_RST)) dut (
        .clk(clk), .reset(reset),
        .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
        .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
        .wr_n(wr_n), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_n(rsv_n), .rsv_addr(rsv_addr),
        .pc_inc(pc_inc), .pc_out(pc_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc_cnt = 0;
    int   errors  = 0;
    int   checks  = 0;
    logic [15:0] got;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_RA_DATA: return ra_data;
            S_RB_DATA: return rb_data;
            S_RA_BUSY: return {15'd0, ra_busy};
            S_RB_BUSY: return {15'd0, rb_busy};
            S_PC:      return pc_out;
            default:   return {8'd0, busy};
        endcase
    endfunction

    // Monitor: every expectation tagged for this cycle is compared at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            mon_e  = sb.pop_front();
            got    = observe(mon_e.sel);
            checks = checks + 1;
            if (mon_e.cyc != cyc_cnt || got !== mon_e.exp) begin
                errors = errors + 1;
                $display("FAIL %s: got %h, expected %h (cycle %0d, tagged %0d)",
                         mon_e.name, got, mon_e.exp, cyc_cnt, mon_e.cyc);
            end
        end
    end

    task automatic push_exp(input string nm, input int sel, input logic [15:0] v);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = v;
        e.cyc  = cyc_cnt;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_n   = 1'b1;
        rsv_n  = 1'b1;
        pc_inc = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        wr_n = 1'b0; wr_addr = a; wr_data = d;
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        ra_addr = 3'd0; rb_addr = 3'd0;
        wr_addr = 3'd0; wr_data = 16'h0; rsv_addr = 3'd0;
        idle();
        tick();

        // Reset state, with clock running and strobes idle.
        for (int i = 0; i < 4; i++) begin
            ra_addr = 3'(i);
            rb_addr = 3'(i + 4);
            push_exp($sformatf("rst_r%0d", i), S_RA_DATA, 16'h0);
            push_exp($sformatf("rst_r%0d", i + 4), S_RB_DATA, (i + 4 == 7) ? PC_RST : 16'h0);
            tick();
        end
        push_exp("rst_pc", S_PC, PC_RST);
        push_exp("rst_busy", S_BUSY, 16'h0);

        reset = 1'b0;
        pc_inc = 1'b1;
        tick(); tick(); tick();
        pc_inc = 1'b0;
        ra_addr = 3'd7;
        push_exp("pc_inc3", S_PC, 16'h0003);
        push_exp("r7_read_pc", S_RA_DATA, 16'h0003);

        do_write(3'd2, 16'hBEEF);
        ra_addr = 3'd2; rb_addr = 3'd1;
        push_exp("wr_r2", S_RA_DATA, 16'hBEEF);
        push_exp("r1_untouched", S_RB_DATA, 16'h0);
        tick();
        ra_addr = 3'd3; rb_addr = 3'd7;
        push_exp("r3_untouched", S_RA_DATA, 16'h0);
        push_exp("pc_held", S_RB_DATA, 16'h0003);

        rsv_n = 1'b0; rsv_addr = 3'd5;
        tick();
        idle();
        rb_addr = 3'd5; ra_addr = 3'd4;
        push_exp("rsv5_busy", S_BUSY, 16'h0020);
        push_exp("rsv5_rb_busy", S_RB_BUSY, 16'h1);
        push_exp("r4_not_busy", S_RA_BUSY, 16'h0);
        do_write(3'd5, 16'h1234);
        push_exp("wr5_clears", S_BUSY, 16'h0000);
        push_exp("wr5_data", S_RB_DATA, 16'h1234);

        rsv_n = 1'b0; rsv_addr = 3'd3;
        wr_n = 1'b0; wr_addr = 3'd3; wr_data = 16'h00AA;
        tick();
        idle();
        ra_addr = 3'd3;
        push_exp("rsv_wr_same_data", S_RA_DATA, 16'h00AA);
        push_exp("rsv_wr_same_busy", S_BUSY, 16'h0008);
        push_exp("rsv_wr_ra_busy", S_RA_BUSY, 16'h1);

        wr_n = 1'b0; wr_addr = 3'd7; wr_data = 16'h0100; pc_inc = 1'b1;
        tick();
        idle();
        push_exp("wr_beats_inc", S_PC, 16'h0100);

        rsv_n = 1'b0; rsv_addr = 3'd7;
        tick();
        idle();
        pc_inc = 1'b1;
        tick();
        idle();
        push_exp("inc_keeps_busy7_pc", S_PC, 16'h0101);
        push_exp("inc_keeps_busy7", S_BUSY, 16'h0088);

        do_write(3'd7, 16'hFFFF);
        push_exp("wr7_pc", S_PC, 16'hFFFF);
        push_exp("wr7_clears_busy", S_BUSY, 16'h0008);
        pc_inc = 1'b1;
        tick();
        idle();
        push_exp("pc_wrap", S_PC, 16'h0000);

        do_write(3'd0, 16'h0F0F);
        ra_addr = 3'd0; rb_addr = 3'd1;
        push_exp("r0_writable", S_RA_DATA, 16'h0F0F);
        push_exp("r1_still0", S_RB_DATA, 16'h0);

        // Forwarding behaviour: same-cycle view of a write in flight.
        do_write(3'd6, 16'h1111);
        rsv_n = 1'b0; rsv_addr = 3'd6;
        tick();
        idle();
        wr_n = 1'b0; wr_addr = 3'd6; wr_data = 16'h5A5A; ra_addr = 3'd6;
`ifdef REGFILE_BYPASS_EN
        push_exp("byp_ra_data", S_RA_DATA, 16'h5A5A);
        push_exp("byp_ra_busy", S_RA_BUSY, 16'h0);
`else
        push_exp("nobyp_ra_data", S_RA_DATA, 16'h1111);
        push_exp("nobyp_ra_busy", S_RA_BUSY, 16'h1);
`endif
        tick();
        idle();
        wr_n = 1'b0; wr_addr = 3'd6; wr_data = 16'hA5A5;
        rsv_n = 1'b0; rsv_addr = 3'd6; rb_addr = 3'd6;
`ifdef REGFILE_BYPASS_EN
        push_exp("byp_rb_data", S_RB_DATA, 16'hA5A5);
        push_exp("byp_rb_busy_rsv", S_RB_BUSY, 16'h1);
`else
        push_exp("nobyp_rb_data", S_RB_DATA, 16'h5A5A);
        push_exp("nobyp_rb_busy", S_RB_BUSY, 16'h0);
`endif
        tick();
        idle();
        wr_n = 1'b0; wr_addr = 3'd7; wr_data = 16'h2222; ra_addr = 3'd7;
        push_exp("pc_not_bypassed", S_PC, 16'h0000);
`ifdef REGFILE_BYPASS_EN
        push_exp("byp_r7_read", S_RA_DATA, 16'h2222);
`else
        push_exp("nobyp_r7_read", S_RA_DATA, 16'h0000);
`endif
        tick();
        idle();
        push_exp("r7_written", S_PC, 16'h2222);
        push_exp("r6_final", S_RB_DATA, 16'hA5A5);
        push_exp("busy_before_rst", S_BUSY, 16'h0048);

        // Asynchronous reset landing mid-cycle while a write to R4 is pending.
        do_write(3'd4, 16'h4444);
        ra_addr = 3'd4;
        push_exp("r4_written", S_RA_DATA, 16'h4444);
        tick();
        wr_n = 1'b0; wr_addr = 3'd4; wr_data = 16'h7777;
        rb_addr = 3'd7;
        #2;
        reset = 1'b1;
        push_exp("async_rst_r4", S_RA_DATA, 16'h0);
        push_exp("async_rst_r7", S_RB_DATA, PC_RST);
        push_exp("async_rst_pc", S_PC, PC_RST);
        push_exp("async_rst_busy", S_BUSY, 16'h0);
        tick();
        reset = 1'b0;
        idle();
        ra_addr = 3'd4; rb_addr = 3'd2;
        push_exp("rst_discards_wr", S_RA_DATA, 16'h0);
        push_exp("rst_clears_r2", S_RB_DATA, 16'h0);
        tick();
        tick();

        if (sb.size() != 0) begin
            checks = checks + sb.size();
            errors = errors + sb.size();
            $display("FAIL unchecked: %0d expectations never compared", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
